// File: rtl/pfa_pkg.sv
// Shared widths for the PFA address translator and its divide-by-7 helper.
package pfa_pkg;
  localparam int DEF_W = 16;
  localparam int DIV_W = 12;
  localparam int QUO_W = 10;
  localparam int REM_W = 3;
endpackage

// File: rtl/pfa_addr_trans_divider_7.sv
// Combinational divide-by-7 of a 12-bit value via reciprocal multiply.
module divider_7
  import pfa_pkg::*;
(
  input  logic [DIV_W-1:0] dividend,
  output logic [QUO_W-1:0] quotient,
  output logic [REM_W-1:0] remainder
);
  // 2341/2^14 overshoots 1/7 by less than 1/(7*4096) per unit, exact for 12-bit inputs
  logic [23:0]       prod;
  logic [DIV_W-1:0]  back;

  assign prod      = {12'd0, dividend} * 24'd2341;
  assign quotient  = QUO_W'(prod >> 14);
  assign back      = DIV_W'({2'b00, quotient} * 12'd7);
  assign remainder = REM_W'(dividend - back);
endmodule

// File: rtl/pfa_addr_trans.sv
// Prime-factor-algorithm index/address generator: three modular digit counters plus linear address.
// Optional divide-by-7 of the address enabled by PFA_ADDR_DIV7_EN; otherwise addr_quo/addr_rem are 0.
module pfa_addr_trans
  import pfa_pkg::*;
#(
  parameter int wDataInOut = DEF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [wDataInOut-1:0] Nf1,
  input  logic [wDataInOut-1:0] Nf2,
  input  logic [wDataInOut-1:0] Nf3,
  input  logic [wDataInOut-1:0] q_p,
  input  logic [wDataInOut-1:0] r_p,
  output logic [wDataInOut-1:0] n1,
  output logic [wDataInOut-1:0] n2,
  output logic [wDataInOut-1:0] n3,
  output logic [wDataInOut-1:0] addr,
  output logic [QUO_W-1:0]      addr_quo,
  output logic [REM_W-1:0]      addr_rem
);
  localparam int W = wDataInOut;

  // One extra bit keeps the sum exact before the compare against the factor
  logic [W:0] s1, s2, s3;
  logic [W:0] m1, m2, m3;

  assign s1 = {1'b0, n1} + {1'b0, q_p};
  assign s2 = {1'b0, n2} + {1'b0, r_p};
  assign s3 = {1'b0, n3} + {{W{1'b0}}, 1'b1};

  assign m1 = (s1 >= {1'b0, Nf1}) ? s1 - {1'b0, Nf1} : s1;
  assign m2 = (s2 >= {1'b0, Nf2}) ? s2 - {1'b0, Nf2} : s2;
  assign m3 = (s3 >= {1'b0, Nf3}) ? s3 - {1'b0, Nf3} : s3;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      n1 <= '0;
      n2 <= '0;
      n3 <= '0;
    end else begin
      n1 <= m1[W-1:0];
      n2 <= m2[W-1:0];
      n3 <= m3[W-1:0];
    end
  end

  assign addr = n1 * Nf2 * Nf3 + n2 * Nf3 + n3;

`ifdef PFA_ADDR_DIV7_EN
  divider_7 u_div7 (
    .dividend  (addr[DIV_W-1:0]),
    .quotient  (addr_quo),
    .remainder (addr_rem)
  );
`else
  assign addr_quo = '0;
  assign addr_rem = '0;
`endif
endmodule

// File: tb/tb_pfa_addr_trans.sv
// Directed bench for pfa_addr_trans with N=(4,5,3), q'=3, r'=2, plus exhaustive divider_7 check.
module tb_pfa_addr_trans;
  import pfa_pkg::*;

`ifdef PFA_ADDR_DIV7_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [15:0] Nf1, Nf2, Nf3, q_p, r_p;
  logic [15:0] n1, n2, n3, addr;
  logic [9:0]  addr_quo;
  logic [2:0]  addr_rem;

  logic [11:0] dv;
  logic [9:0]  dq;
  logic [2:0]  dr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pfa_addr_trans #(.wDataInOut(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .Nf1(Nf1), .Nf2(Nf2), .Nf3(Nf3), .q_p(q_p), .r_p(r_p),
    .n1(n1), .n2(n2), .n3(n3), .addr(addr),
    .addr_quo(addr_quo), .addr_rem(addr_rem)
  );

  divider_7 u_div (.dividend(dv), .quotient(dq), .remainder(dr));

  typedef struct {
    int step;
    int n1, n2, n3, addr, quo, rem;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int e1, input int e2, input int e3,
                           input int ea, input int eq, input int er);
    chk({tag, ".n1"}, int'(n1), e1);
    chk({tag, ".n2"}, int'(n2), e2);
    chk({tag, ".n3"}, int'(n3), e3);
    chk({tag, ".addr"}, int'(addr), ea);
    chk({tag, ".quo"}, int'(addr_quo), DIV_EN ? eq : 0);
    chk({tag, ".rem"}, int'(addr_rem), DIV_EN ? er : 0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit seen[60];

    vecs[0] = '{0,  0, 0, 0,  0, 0, 0};
    vecs[1] = '{1,  3, 2, 1, 52, 7, 3};
    vecs[2] = '{2,  2, 4, 2, 44, 6, 2};
    vecs[3] = '{3,  1, 1, 0, 18, 2, 4};
    vecs[4] = '{59, 1, 3, 2, 26, 3, 5};
    vecs[5] = '{60, 0, 0, 0,  0, 0, 0};

    Nf1 = 16'd4; Nf2 = 16'd5; Nf3 = 16'd3; q_p = 16'd3; r_p = 16'd2;
    dv  = '0;

    // rst and clr together behave as reset
    rst = 1'b1; clr = 1'b1;
    step();
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_state("clr_hold", 0, 0, 0, 0, 0, 0);

    clr = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) step();
      if (k < 60) begin
        if (addr < 16'd60) seen[addr] = 1'b1;
      end
      foreach (vecs[i])
        if (vecs[i].step == k)
          chk_state($sformatf("step%0d", k), vecs[i].n1, vecs[i].n2, vecs[i].n3,
                    vecs[i].addr, vecs[i].quo, vecs[i].rem);
    end
    begin
      int cnt = 0;
      foreach (seen[i]) if (seen[i]) cnt++;
      chk("addr_coverage", cnt, 60);
    end

    // clr mid-sequence
    for (int k = 0; k < 7; k++) step();
    clr = 1'b1;
    step();
    chk_state("mid_clr", 0, 0, 0, 0, 0, 0);
    clr = 1'b0;
    step();
    chk_state("after_clr", 3, 2, 1, 52, 7, 3);

    // rst mid-sequence, released with clr low
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    chk_state("mid_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_state("after_rst", 3, 2, 1, 52, 7, 3);

    // factors of 1 pin their digits to 0
    clr = 1'b1;
    Nf1 = 16'd1; q_p = 16'd0; Nf3 = 16'd1;
    step();
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("f1.n1_%0d", k), int'(n1), 0);
      chk($sformatf("f1.n3_%0d", k), int'(n3), 0);
      chk($sformatf("f1.n2_%0d", k), int'(n2), (2 * k) % 5);
      chk($sformatf("f1.addr_%0d", k), int'(addr), (2 * k) % 5);
    end

    // divider_7 exhaustive
    for (int d = 0; d < 4096; d++) begin
      dv = 12'(d);
      #1;
      if (int'(dq) * 7 + int'(dr) != d || dr >= 3'd7) begin
        chk($sformatf("div7_%0d", d), int'(dq) * 7 + int'(dr), d);
      end else begin
        checks++;
      end
    end
    dv = 12'd4095; #1;
    chk("div7_4095_q", int'(dq), 585);
    chk("div7_4095_r", int'(dr), 0);
    dv = 12'd6; #1;
    chk("div7_6_q", int'(dq), 0);
    chk("div7_6_r", int'(dr), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pfa_addr_trans.md
PFA_ADDR_TRANS -- requirements
Module: pfa_addr_trans

Interface
REQ-001 Parameter wDataInOut, default 16, width of all factor, inverse, index and address ports.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 clr  input  1  synchronous active-high sequence restart.
REQ-005 Nf1  input  wDataInOut  factor N1.
REQ-006 Nf2  input  wDataInOut  factor N2.
REQ-007 Nf3  input  wDataInOut  factor N3.
REQ-008 q_p  input  wDataInOut  q' = (N2*N3)^-1 mod N1.
REQ-009 r_p  input  wDataInOut  r' = N3^-1 mod N2.
REQ-010 n1  output  wDataInOut  first PFA index digit, registered.
REQ-011 n2  output  wDataInOut  second PFA index digit, registered.
REQ-012 n3  output  wDataInOut  third PFA index digit, registered.
REQ-013 addr  output  wDataInOut  linear address n1*Nf2*Nf3 + n2*Nf3 + n3, truncated to wDataInOut bits.
REQ-014 addr_quo  output  10  addr[11:0] div 7.
REQ-015 addr_rem  output  3  addr[11:0] mod 7.

Function
REQ-016 Each clk edge with rst=0 and clr=0 shall update n1 <= (n1+q_p) mod Nf1, n2 <= (n2+r_p) mod Nf2, n3 <= (n3+1) mod Nf3.
REQ-017 Each modular step shall be one add plus one conditional subtract (sum >= Nf ? sum-Nf : sum); no divider in the counter path.
REQ-018 Sequence step k shall therefore give n1=k*q_p mod N1, n2=k*r_p mod N2, n3=k mod N3, with period N1*N2*N3.
REQ-019 The sequence shall wrap back to (0,0,0) after N1*N2*N3 steps with no idle cycle.
REQ-020 clr=1 on a clk edge shall load n1=n2=n3=0; the first advance happens on the first edge with clr=0.
REQ-021 Simultaneous rst and clr shall behave as rst.
REQ-022 addr, addr_quo and addr_rem shall be combinational from the n registers, valid in the same cycle as n1..n3.
REQ-023 Inputs shall satisfy Nf1..Nf3 >= 1, q_p < Nf1, r_p < Nf2, and shall change only while clr=1; other cases are outside the contract.
REQ-024 A factor of 1 shall hold its digit at 0.
REQ-025 Intermediate sums shall be wDataInOut+1 bits to avoid overflow before the compare.

Reset
REQ-026 rst=1 on a clk edge shall set n1=n2=n3=0, so addr=0, addr_quo=0 and addr_rem=0 next cycle.
REQ-027 rst asserted mid-sequence shall abort the sequence; after release it restarts from (0,0,0) under the clr rules.

Configuration
REQ-028 Macro PFA_ADDR_DIV7_EN defined: addr_quo/addr_rem driven by the divide-by-7 sub-module.
REQ-029 Macro PFA_ADDR_DIV7_EN undefined: no divider instantiated; addr_quo and addr_rem tied to 0; all other behaviour unchanged.

Structure
REQ-030 Shared package pfa_pkg shall hold the default width constant (16), the divider dividend width (12), the quotient width (10) and the remainder width (3).
REQ-031 Sub-module divider_7 shall be purely combinational.
REQ-032 divider_7 ports: dividend[11:0] in, quotient[9:0] out, remainder[2:0] out.
REQ-033 divider_7 outputs shall satisfy dividend = 7*quotient + remainder, remainder < 7, over all 4096 inputs.

Verification (Nf1=4, Nf2=5, Nf3=3, q_p=3, r_p=2)
REQ-034 rst high then clr high -> n=(0,0,0), addr=0, addr_quo=0, addr_rem=0.
REQ-035 clr drops -> (n1,n2,n3) over successive cycles = (0,0,0), (3,2,1), (2,4,2), (1,1,0); addr = 0, 52, 44, 18.
REQ-036 Step 59 -> (1,3,2), addr=26, addr_quo=3, addr_rem=5; step 60 -> (0,0,0).
REQ-037 Over 60 steps, all 60 addr values 0..59 appear exactly once.
REQ-038 clr pulsed mid-sequence -> (0,0,0) next cycle, then (3,2,1).
REQ-039 divider_7 exhaustive check: dividend 0..4095, including 4095 -> quotient 585, remainder 0, and 6 -> quotient 0, remainder 6.
